// File: rtl/seg7_pkg.sv
// Shared constants and state encoding for the 7-segment scan controller.
// Leading-zero blanking is enabled elsewhere by defining SEG7_LZB_EN.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK     = 7'h7F;
   localparam int         DEF_PRESCALE  = 50000;
   localparam int         DEF_BLANK_CYC = 16;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// LOAD/READY handshake bundle between the CPU port register and the scan controller.
interface seg7_scan_ctrl_if #(
   parameter int NDIG = 4
);

   logic                load;
   logic [4*NDIG-1:0]   data;
   logic                ready;

   modport master (output load, output data, input ready);
   modport slave  (input load, input data, output ready);

endinterface

// File: rtl/seg7_scan_ctrl_dec_7seg.sv
// BCD to common-anode 7-segment decoder, active-low, bit 6 = g ... bit 0 = a.
// Codes above 9 decode to X; the caller masks them.
module dec_7seg (
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = 'x;
      case (bcd)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = 'x;
      endcase
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed NDIG-digit 7-segment scan controller with frame-synchronous updates.
// Define SEG7_LZB_EN to blank leading zeros.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NDIG      = 4,
   parameter int PRESCALE  = DEF_PRESCALE,
   parameter int BLANK_CYC = DEF_BLANK_CYC
) (
   input  logic                 clk,
   input  logic                 rst_n,
   seg7_scan_ctrl_if.slave      bus,
   output logic [NDIG-1:0]      dig_sel,
   output logic [6:0]           seg7,
   output logic                 frame_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

   logic [CW-1:0]      cnt, cnt_nxt;
   logic [DW-1:0]      dig, dig_nxt;
   scan_state_t        state, state_nxt;
   logic               wrap;

   logic [4*NDIG-1:0]  active;
   logic [4*NDIG-1:0]  pending;
   logic               pend;

   logic [3:0]         nibble;
   logic [6:0]         dec_seg;
   logic               lz_blank;
   logic [NDIG-1:0]    sel_nxt;
   logic [6:0]         seg_nxt;

   assign bus.ready = ~pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         dig   <= '0;
         state <= ST_BLANK;
      end else begin
         cnt   <= cnt_nxt;
         dig   <= dig_nxt;
         state <= state_nxt;
      end
   end

   // The state always mirrors the slot position: the first BLANK_CYC cycles are dead time.
   always_comb begin
      cnt_nxt = cnt + 1'b1;
      dig_nxt = dig;
      wrap    = 1'b0;
      if (cnt == CW'(PRESCALE - 1)) begin
         cnt_nxt = '0;
         if (dig == DW'(NDIG - 1)) begin
            dig_nxt = '0;
            wrap    = 1'b1;
         end else begin
            dig_nxt = dig + 1'b1;
         end
      end
      state_nxt = (cnt_nxt < CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;
   end

   // A pending word is only committed at the frame wrap, so a frame is never torn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active  <= '0;
         pending <= '0;
         pend    <= 1'b0;
      end else if (wrap && pend) begin
         active  <= pending;
         pend    <= 1'b0;
      end else if (bus.load && !pend) begin
         pending <= bus.data;
         pend    <= 1'b1;
      end
   end

   always_comb begin
      nibble = 4'h0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig == DW'(i)) nibble = active[4*i +: 4];
      end
   end

   dec_7seg u_dec (
      .bcd (nibble),
      .seg (dec_seg)
   );

`ifdef SEG7_LZB_EN
   logic [NDIG-1:0] lz_mask;
   logic            lz_run;

   // A digit is a leading zero if it and every digit above it hold zero; digit 0 always shows.
   always_comb begin
      lz_mask = '0;
      lz_run  = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         lz_run     = lz_run & (active[4*i +: 4] == 4'h0);
         lz_mask[i] = lz_run;
      end
      lz_blank = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         if (dig == DW'(i)) lz_blank = lz_mask[i];
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      sel_nxt = '1;
      seg_nxt = SEG_BLANK;
      if (state == ST_SHOW) begin
         sel_nxt[dig] = 1'b0;
         if (nibble <= 4'd9 && !lz_blank) seg_nxt = dec_seg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dig_sel    <= '1;
         seg7       <= SEG_BLANK;
         frame_tick <= 1'b0;
      end else begin
         dig_sel    <= sel_nxt;
         seg7       <= seg_nxt;
         frame_tick <= wrap;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl (NDIG=4, PRESCALE=8, BLANK_CYC=2); honours SEG7_LZB_EN.
module tb_seg7_scan_ctrl;

   localparam int NDIG      = 4;
   localparam int PRESCALE  = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME     = NDIG * PRESCALE;

   typedef struct {
      logic [6:0] seg;
      logic [3:0] sel;
      logic       tick;
      logic       rdy;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] dig_sel;
   logic [6:0] seg7;
   logic       frame_tick;

   int checks = 0;
   int errors = 0;

   exp_t exp_q[$];

   int          m_e = 0;
   logic        m_pend = 1'b0;
   logic [15:0] m_active = '0;
   logic [15:0] m_pending = '0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   seg7_scan_ctrl_if #(.NDIG(NDIG)) bus ();

   seg7_scan_ctrl #(
      .NDIG      (NDIG),
      .PRESCALE  (PRESCALE),
      .BLANK_CYC (BLANK_CYC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .dig_sel    (dig_sel),
      .seg7       (seg7),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] ref_seg(input logic [15:0] word, input int d);
      logic [3:0] n;
      n = word[4*d +: 4];
      if (n > 4'd9) return 7'h7F;
`ifdef SEG7_LZB_EN
      if (d > 0 && (word >> (4*d)) == 16'h0) return 7'h7F;
`endif
      return seg_tab[n];
   endfunction

   // Reference model: slot position comes straight from the edge count since reset.
   always @(posedge clk) begin
      int   p, d, off;
      exp_t e;
      if (!rst_n) begin
         m_e       = 0;
         m_pend    = 1'b0;
         m_active  = '0;
         m_pending = '0;
      end else begin
         p     = m_e % FRAME;
         d     = p / PRESCALE;
         off   = p % PRESCALE;
         e.sel = (off < BLANK_CYC) ? 4'hF : ~(4'b0001 << d);
         e.seg = (off < BLANK_CYC) ? 7'h7F : ref_seg(m_active, d);
         e.tick = (p == FRAME - 1);
         if (p == FRAME - 1 && m_pend) begin
            m_active = m_pending;
            m_pend   = 1'b0;
         end else if (bus.load && !m_pend) begin
            m_pending = bus.data;
            m_pend    = 1'b1;
         end
         e.rdy = !m_pend;
         exp_q.push_back(e);
         m_e++;
      end
   end

   task automatic compareOne(input string name, input logic [6:0] got, input logic [6:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at t=%0t", name, got, want, $time);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      compareOne("seg7", seg7, e.seg);
      compareOne("dig_sel", {3'b000, dig_sel}, {3'b000, e.sel});
      compareOne("frame_tick", {6'b0, frame_tick}, {6'b0, e.tick});
      compareOne("ready", {6'b0, bus.ready}, {6'b0, e.rdy});
   endtask

   task automatic checkReset();
      compareOne("rst_seg7", seg7, 7'h7F);
      compareOne("rst_dig_sel", {3'b000, dig_sel}, 7'h0F);
      compareOne("rst_frame_tick", {6'b0, frame_tick}, 7'h00);
      compareOne("rst_ready", {6'b0, bus.ready}, 7'h01);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput(e);
      end
   end

   task automatic applyStimulus(input logic ld, input logic [15:0] d);
      @(negedge clk);
      bus.load = ld;
      bus.data = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0000);
   endtask

   // Assert reset between edges so the asynchronous path is exercised on its own.
   task automatic resetPulse();
      #2;
      rst_n    = 1'b0;
      bus.load = 1'b0;
      #1;
      checkReset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] rd;
      int          waited;
      bit          found;
      bus.load = 1'b0;
      bus.data = '0;
      repeat (2) @(negedge clk);
      checkReset();
      rst_n = 1'b1;

      idle(40);
      applyStimulus(1'b1, 16'h1234);
      applyStimulus(1'b1, 16'h9999);
      idle(70);
      applyStimulus(1'b1, 16'h00A5);
      idle(70);

      for (int i = 0; i < 300; i++) begin
         rd = ($urandom_range(0, 1) == 0) ? 16'($urandom)
                                          : {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                             4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
         if ($urandom_range(0, 3) == 0) rd = {8'h00, rd[7:0]};
         applyStimulus($urandom_range(0, 5) == 0, rd);
      end

      waited = 0;
      found  = 1'b0;
      while (!found && waited < 200) begin
         applyStimulus(!m_pend, 16'h5678);
         waited++;
         if (m_pend && ((m_e - 1) % FRAME) >= 19 && ((m_e - 1) % FRAME) <= 22) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL reset_window got timeout expected digit2 show with pend");
      end
      resetPulse();
      idle(80);
      applyStimulus(1'b1, 16'h0907);
      idle(80);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
